// File: rtl/regfile_multiport.sv
// Two-write / two-read register file with a sequential clear sweep.
// Reads are combinational, with optional same-cycle write forwarding.
module regfile_multiport #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1,
  localparam int AW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_req,
  output logic            ready,
  input  logic            we0,
  input  logic            we1,
  input  logic [AW-1:0]   waddr0,
  input  logic [AW-1:0]   waddr1,
  input  logic [XLEN-1:0] wdata0,
  input  logic [XLEN-1:0] wdata1,
  input  logic [AW-1:0]   raddr0,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata0,
  output logic [XLEN-1:0] rdata1
);

  typedef enum logic {S_CLEAR = 1'b0, S_IDLE = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0] mem [NREGS];

  logic            wr0_en, wr1_en;
  logic [1:0][AW-1:0]   raddr_v;
  logic [1:0][XLEN-1:0] rdata_v;
  logic [1:0]           hit0, hit1;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NREGS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clr_req) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign ready = (state_q == S_IDLE);

  // rst is sampled here so a reset landing on a write edge cannot commit it.
  assign wr0_en = rst && ready && we0 && !((ZERO_REG0 != 0) && (waddr0 == '0));
  assign wr1_en = rst && ready && we1 && !((ZERO_REG0 != 0) && (waddr1 == '0));

  // Storage has no reset; the sweep is the only thing that zeroes it.
  always_ff @(posedge clk) begin
    if (rst && !ready) begin
      mem[clr_cnt_q] <= '0;
    end else begin
      if (wr0_en) mem[waddr0] <= wdata0;
      if (wr1_en) mem[waddr1] <= wdata1;
    end
  end

  assign raddr_v[0] = raddr0;
  assign raddr_v[1] = raddr1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign hit0[gi] = (BYPASS != 0) && we0 && (waddr0 == raddr_v[gi]);
      assign hit1[gi] = (BYPASS != 0) && we1 && (waddr1 == raddr_v[gi]);
      // Port 1 forwarding sits outermost so it wins over port 0.
      assign rdata_v[gi] = (!ready || ((ZERO_REG0 != 0) && (raddr_v[gi] == '0))) ? '0 :
                           hit1[gi] ? wdata1 :
                           hit0[gi] ? wdata0 :
                           mem[raddr_v[gi]];
    end
  endgenerate

  assign rdata0 = rdata_v[0];
  assign rdata1 = rdata_v[1];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: a default instance plus a BYPASS=0
// instance on shared inputs, checked against a queue of expected values.
module tb_regfile_multiport;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        we0, we1;
  logic [4:0]  waddr0, waddr1, raddr0, raddr1;
  logic [31:0] wdata0, wdata1;
  logic        ready, nb_ready;
  logic [31:0] rdata0, rdata1, nb_rdata0, nb_rdata1;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];

  regfile_multiport dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(rdata0), .rdata1(rdata1)
  );

  regfile_multiport #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(nb_ready),
    .we0(we0), .we1(we1), .waddr0(waddr0), .waddr1(waddr1),
    .wdata0(wdata0), .wdata1(wdata1), .raddr0(raddr0), .raddr1(raddr1),
    .rdata0(nb_rdata0), .rdata1(nb_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, expected queue empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts rising edges until ready rises, bounded.
  task automatic count_to_ready(output int n);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (ready) break;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; clr_req = 1'b0; we0 = 1'b0; we1 = 1'b0;
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr0 = 5'd3; raddr1 = 5'd4;

    // Reset state
    #3;
    push(32'd0); check("rst_ready", 32'(ready));
    push(32'd0); check("rst_rdata0", rdata0);
    push(32'd0); check("rst_rdata1", rdata1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    count_to_ready(n);
    push(32'd32); check("init_clear_cycles", 32'(n));

    for (int i = 0; i < 32; i++) begin
      raddr0 = 5'(i); raddr1 = 5'(31 - i);
      push(32'd0); push(32'd0);
      #1;
      check("init_r0", rdata0);
      check("init_r1", rdata1);
    end

    // Seed x5 so the non-forwarding instance has a distinct old value
    tick();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h0BADF00D;
    tick();
    we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hABCDEFFF; raddr0 = 5'd5;
    push(32'hABCDEFFF); push(32'h0BADF00D);
    #1;
    check("byp_x5", rdata0);
    check("nobyp_x5_old", nb_rdata0);
    tick();
    we0 = 1'b0;
    push(32'hABCDEFFF); push(32'hABCDEFFF);
    #1;
    check("x5_stored", rdata0);
    check("nobyp_x5_stored", nb_rdata0);

    // x0 is hardwired
    we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h12345678; raddr1 = 5'd0;
    push(32'd0);
    #1;
    check("x0_byp", rdata1);
    tick();
    we1 = 1'b0;
    push(32'd0);
    #1;
    check("x0_after", rdata1);

    // Port 0 forwards to read port 1
    we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h00009999; raddr1 = 5'd9;
    push(32'h00009999); push(32'd0);
    #1;
    check("byp_p0_to_r1", rdata1);
    check("nobyp_p0_to_r1", nb_rdata1);
    tick();

    // Same-address collision: port 1 wins
    we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
    we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
    raddr0 = 5'd7; raddr1 = 5'd7;
    push(32'h22222222); push(32'h22222222);
    #1;
    check("collide_byp_r0", rdata0);
    check("collide_byp_r1", rdata1);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    push(32'h22222222); push(32'h22222222);
    #1;
    check("collide_stored", rdata0);
    check("nobyp_collide_stored", nb_rdata1);

    // Populate x1..x31, two per cycle
    for (int i = 1; i < 32; i += 2) begin
      tick();
      we0 = 1'b1; waddr0 = 5'(i); wdata0 = pat(i);
      if (i + 1 < 32) begin
        we1 = 1'b1; waddr1 = 5'(i + 1); wdata1 = pat(i + 1);
      end else begin
        we1 = 1'b0;
      end
    end
    tick();
    we0 = 1'b0; we1 = 1'b0;
    for (int i = 1; i < 32; i++) begin
      raddr0 = 5'(i);
      push(pat(i));
      #1;
      check("populate", rdata0);
    end

    // Clear sweep: re-request and an x3 write mid-sweep must both be ignored
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0; raddr0 = 5'd1;
    push(32'd0); push(32'd0);
    #1;
    check("clr_ready", 32'(ready));
    check("clr_rdata_gated", rdata0);
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (n == 5) clr_req = 1'b1;
      if (n == 6) clr_req = 1'b0;
      if (n == 20) begin
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEADBEEF;
      end
      if (n == 21) we0 = 1'b0;
      if (ready) break;
    end
    clr_req = 1'b0; we0 = 1'b0;
    push(32'd32); check("clr_cycles", 32'(n));
    for (int i = 0; i < 32; i++) begin
      raddr0 = 5'(i); raddr1 = 5'(31 - i);
      push(32'd0); push(32'd0);
      #1;
      check("post_clr_r0", rdata0);
      check("post_clr_r1", rdata1);
    end

    // Refill x12, then reset when clr_cnt reaches 10
    we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h0C0C0C0C;
    tick();
    we1 = 1'b0; raddr1 = 5'd12;
    push(32'h0C0C0C0C);
    #1;
    check("x12_refill", rdata1);
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b0;
    push(32'd0); push(32'd0);
    #1;
    check("midclr_rst_ready", 32'(ready));
    check("midclr_rst_rdata1", rdata1);
    tick();
    tick();
    rst = 1'b1;
    count_to_ready(n);
    push(32'd32); check("midclr_restart_cycles", 32'(n));
    push(32'd0);
    #1;
    check("midclr_x12_zero", rdata1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
